// File: rtl/fire_pkg.sv
// Shared types and defaults for the fire-button conditioner.
package fire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_PRESS,
    PRESSED,
    BOUNCE_RELEASE,
    STUCK
  } fire_state_t;

  // 10 ms debounce and 3 s stuck limit at 100 MHz
  localparam int unsigned FIRE_DB_CYCLES_DEF    = 1_000_000;
  localparam int unsigned FIRE_STUCK_CYCLES_DEF = 300_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous level inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fire_conditioner.sv
// Debounces the fire button into single-cycle pulses, tracks arming and
// latches a sticky error when the button is held down too long.
module fire_conditioner
  import fire_pkg::*;
#(
  parameter int unsigned DB_CYCLES    = FIRE_DB_CYCLES_DEF,
  parameter int unsigned STUCK_CYCLES = FIRE_STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_fire,
  input  logic arm_sw,
  input  logic clear_err,
  output logic fire,
  output logic armed,
  output logic error
);

  localparam int CW = $clog2(STUCK_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  logic btn_s;
  logic arm_s;

  sync_2ff u_sync_btn (.clk(clk), .rst_n(reset), .d_i(btn_fire), .q_o(btn_s));
  sync_2ff u_sync_arm (.clk(clk), .rst_n(reset), .d_i(arm_sw),   .q_o(arm_s));

  fire_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire_q, fire_d;
  logic          armed_q;
  logic          error_q, error_d;
  logic          restart;
  logic          set_err;

  always_comb begin
    state_d = state_q;
    fire_d  = 1'b0;
    set_err = 1'b0;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) state_d = BOUNCE_PRESS;
      end
      BOUNCE_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          fire_d  = arm_s;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = BOUNCE_RELEASE;
        end else if (cnt_q == STUCK_LAST) begin
          state_d = STUCK;
          set_err = 1'b1;
        end
      end
      BOUNCE_RELEASE: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end
      end
      STUCK: begin
        // Any high sample restarts the release qualification
        if (btn_s) begin
          restart = 1'b1;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (set_err) begin
      error_d = 1'b1;
    end else if (clear_err && (state_q != STUCK)) begin
      error_d = 1'b0;
    end else begin
      error_d = error_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fire_q  <= 1'b0;
      armed_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire_d;
      armed_q <= arm_s;
      error_q <= error_d;
    end
  end

  assign fire  = fire_q;
  assign armed = armed_q;
  assign error = error_q;

endmodule

// File: doc/fire_conditioner.md
# fire_conditioner

Input conditioner in front of the BCD shot counter. Synchronises and debounces the raw fire push-button and the arm switch. Emits exactly one single-cycle `fire` pulse per qualified press, and drives a level `armed` that gates counting. Flags a stuck or held-down button on `error`, which feeds the counter's `error` input and the display logic.

## Interface
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a press or release (10 ms at 100 MHz); must be ≥ 2.
- `STUCK_CYCLES`, default 300_000_000: cycles a press may stay held before it is declared stuck (3 s); must be > `DB_CYCLES`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_fire`  in  1  raw, asynchronous, bouncing fire button, active-high.
- `arm_sw`  in  1  raw, asynchronous arm switch, active-high.
- `clear_err`  in  1  synchronous request to clear a latched `error`.
- `fire`  out  1  registered one-cycle pulse per accepted press while armed.
- `armed`  out  1  synchronised `arm_sw` level; connects to counter `enable`.
- `error`  out  1  registered sticky stuck-button flag.

## Operation
- Both raw inputs pass through a 2-flop synchroniser. The FSM and `armed` see only the synchronised `btn_s` / `arm_s`.
- One shared down-counter-free up-counter `cnt`.
  - Width: `$clog2(STUCK_CYCLES+1)`.
  - Cleared on every state change; increments otherwise.
  - Saturates, never wraps.
- States and transitions:
  - IDLE (reset state): `btn_s`=1 → BOUNCE_PRESS.
  - BOUNCE_PRESS:
    - `btn_s`=0 → IDLE, no pulse.
    - `cnt`==`DB_CYCLES`-1 with `btn_s`=1 → PRESSED. On that same edge, `fire` is set for one cycle if `arm_s`=1.
  - PRESSED:
    - `btn_s`=0 → BOUNCE_RELEASE.
    - `cnt`==`STUCK_CYCLES`-1 → STUCK; `error` is set on that edge.
  - BOUNCE_RELEASE:
    - `btn_s`=1 → PRESSED, with no new pulse. The hold count restarts.
    - `cnt`==`DB_CYCLES`-1 with `btn_s`=0 → IDLE.
  - STUCK:
    - No pulses are produced.
    - Leaves to IDLE only after `btn_s`=0 holds for `DB_CYCLES` consecutive cycles. Any `btn_s`=1 during that time restarts `cnt`.
- `error` is sticky.
  - `clear_err`=1 clears it on the next edge only when the state is not STUCK; otherwise the request is ignored.
  - If setting and clearing coincide, set wins.
- `armed` = `arm_s` registered.
  - Arming changes do not abort a press in progress.
  - Only `arm_s` at the qualifying edge decides `fire`.
- At most one `fire` per IDLE→…→PRESSED pass. Two `fire` pulses are always separated by at least 2·`DB_CYCLES` cycles.

## Timing
- Reset (`reset`=0, async): state IDLE, `cnt`=0, synchroniser flops 0, `fire`=0, `armed`=0, `error`=0.
- Reset mid-press discards the press with no pulse. After release of reset, a still-held button needs a full new qualification.
- Press latency:
  - Let edge E be the first rising edge that samples `btn_fire`=1 (stable thereafter).
  - BOUNCE_PRESS is entered at E+2.
  - `fire` is high for exactly the cycle after edge E+2+`DB_CYCLES`.
- Arm latency: `armed` follows `arm_sw` after 3 edges.
- Stuck latency: `error` rises at the edge where PRESSED `cnt` reaches `STUCK_CYCLES`-1, i.e. `STUCK_CYCLES` cycles after entering PRESSED.
- Clear latency: `error` falls one edge after `clear_err` is sampled high.

## Structure
- Shared package `fire_pkg`:
  - state enum `fire_state_t` (IDLE, BOUNCE_PRESS, PRESSED, BOUNCE_RELEASE, STUCK);
  - defaults `FIRE_DB_CYCLES_DEF` and `FIRE_STUCK_CYCLES_DEF`.
- Sub-module `sync_2ff`, single-bit with async active-low reset to 0, instantiated twice.
- FSM, counter and output registers live in `fire_conditioner`.

## Test plan
Bench parameters: `DB_CYCLES`=4, `STUCK_CYCLES`=20.
- Clean press while armed: `arm_sw`=1, then `btn_fire` 0→1 held 10 cycles → exactly one `fire` pulse, after edge E+6; `error` stays 0.
- Bounce: `btn_fire` toggles 1,0,1,0,1 at 1-cycle spacing, then held high → one `fire` only, 4 stable cycles after the last rising toggle.
- Disarmed press: `arm_sw`=0 with a clean press → `fire` never asserts, and the FSM still reaches PRESSED. Arming during the hold gives no late pulse.
- Stuck: hold `btn_fire` for 30 cycles →
  - one `fire`;
  - `error`=1 20 cycles after PRESSED;
  - `clear_err` while held is ignored;
  - after a 4-cycle release, `clear_err` → `error`=0.
- Reset mid-qualification: assert `reset`=0 two cycles into BOUNCE_PRESS → all outputs 0 immediately. After release with the button still high, one `fire` appears `DB_CYCLES`+2 edges later.
- Back-to-back presses, spaced 8 low cycles apart → two `fire` pulses at least 8 cycles apart. Presses spaced 2 low cycles apart → one pulse.
